// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - byte-to-serial word framer, MSB first (optional parity: SERIAL_WORD_TX_PARITY_EN)
module serial_word_tx #(
  parameter int WORD_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] load_data,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       frame_start,
  output logic       ser_last,
  output logic       busy
);

  localparam int W   = 8 * WORD_BYTES;
  localparam int BCW = $clog2(W);
  localparam logic [3:0] LAST_BYTE = 4'(WORD_BYTES - 1);

`ifdef SERIAL_WORD_TX_PARITY_EN
  typedef enum logic [1:0] {FILL, SHIFT, PAR} state_t;
`else
  typedef enum logic {FILL, SHIFT} state_t;
`endif

  state_t           state;
  logic [3:0]       byte_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic [W-1:0]     word;
  logic [W-1:0]     word_next;

  // Bytes shift in from the bottom, so once the word is complete the first
  // accepted byte sits in the top byte position.
  always_comb begin
    word_next = (word << 8) | W'(load_data);
  end

  // Frame state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      byte_cnt    <= '0;
      bit_cnt     <= '0;
      word        <= '0;
      load_ready  <= 1'b1;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      ser_last    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (load_valid && load_ready) begin
            word <= word_next;
            busy <= 1'b1;
            if (byte_cnt == LAST_BYTE) begin
              // Word complete: the first bit goes out in the very next cycle.
              state       <= SHIFT;
              byte_cnt    <= '0;
              bit_cnt     <= BCW'(W - 1);
              load_ready  <= 1'b0;
              ser_valid   <= 1'b1;
              frame_start <= 1'b1;
              ser_out     <= word_next[W-1];
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        SHIFT: begin
          frame_start <= 1'b0;
          if (bit_cnt == '0) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
            // Bit 0 just went out; append the even-parity bit as the last frame bit.
            state    <= PAR;
            ser_out  <= ^word;
            ser_last <= 1'b1;
`else
            state      <= FILL;
            load_ready <= 1'b1;
            ser_valid  <= 1'b0;
            ser_out    <= 1'b0;
            ser_last   <= 1'b0;
            busy       <= 1'b0;
`endif
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            ser_out <= word[bit_cnt - 1'b1];
`ifndef SERIAL_WORD_TX_PARITY_EN
            ser_last <= (bit_cnt == BCW'(1));
`endif
          end
        end
`ifdef SERIAL_WORD_TX_PARITY_EN
        PAR: begin
          state      <= FILL;
          load_ready <= 1'b1;
          ser_valid  <= 1'b0;
          ser_out    <= 1'b0;
          ser_last   <= 1'b0;
          busy       <= 1'b0;
        end
`endif
        default: begin
          state      <= FILL;
          byte_cnt   <= '0;
          load_ready <= 1'b1;
          ser_valid  <= 1'b0;
          ser_out    <= 1'b0;
          ser_last   <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - self-checking bench for serial_word_tx (default build, WORD_BYTES=4)
module tb_serial_word_tx;

  localparam int WB = 4;
  localparam int W  = 8 * WB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] load_data = 8'h00;
  logic       load_valid = 1'b0;
  logic       load_ready, ser_out, ser_valid, frame_start, ser_last, busy;

  int checks = 0;
  int errors = 0;

  serial_word_tx #(.WORD_BYTES(WB)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .ser_last(ser_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: bytes collected so far and the bits of the frame still to send.
  byte unsigned m_bytes[$];
  bit           m_bits[$];

  // Serial capture
  logic [63:0] cap;
  int          flen, idle, gap_last, last_len;
  logic [63:0] last_word;
  logic [31:0] words[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] model_out();
    logic [5:0] v;
    if (m_bits.size() > 0)
      v = {1'b0, 1'b1, m_bits[0], m_bits.size() == W, m_bits.size() == 1, 1'b1};
    else
      v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_bytes.size() != 0};
    return v;
  endfunction

  function automatic logic [5:0] dut_out();
    return {load_ready, ser_valid, ser_out, frame_start, ser_last, busy};
  endfunction

  task automatic model_edge(bit r, bit lv, byte unsigned d);
    logic [31:0] w;
    if (r) begin
      m_bits.delete();
      m_bytes.delete();
    end else if (m_bits.size() > 0) begin
      void'(m_bits.pop_front());
    end else if (lv) begin
      m_bytes.push_back(d);
      if (m_bytes.size() == WB) begin
        w = 0;
        foreach (m_bytes[i]) w = (w << 8) | 32'(m_bytes[i]);
        for (int b = W - 1; b >= 0; b--) m_bits.push_back(w[b]);
        m_bytes.delete();
      end
    end
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic step(bit r, bit lv, byte unsigned d);
    rst = r; load_valid = lv; load_data = d;
    @(posedge clk);
    model_edge(r, lv, d);
    #1;
    chk("cycle_outputs", 64'(dut_out()), 64'(model_out()));
    if (ser_valid) begin
      if (frame_start) begin cap = 0; flen = 0; gap_last = idle; end
      cap = {cap[62:0], ser_out};
      flen++;
      if (ser_last) begin
        last_word = cap; last_len = flen; idle = 0;
        words.push_back(cap[31:0]);
      end
    end else begin
      idle++;
    end
  endtask

  task automatic load_word(logic [31:0] w);
    for (int i = 3; i >= 0; i--) step(0, 1, w[8*i +: 8]);
  endtask

  typedef struct {
    bit           r;
    bit           lv;
    byte unsigned d;
    logic [5:0]   exp;  // {load_ready, ser_valid, ser_out, frame_start, ser_last, busy}
  } vec_t;

  vec_t vecs[11];
  byte unsigned pend[$];
  bit was_ready;

  initial begin
    vecs[0]  = '{1, 1, 8'hAA, 6'b100000};
    vecs[1]  = '{0, 1, 8'h12, 6'b100001};
    vecs[2]  = '{0, 0, 8'h00, 6'b100001};
    vecs[3]  = '{0, 0, 8'h00, 6'b100001};
    vecs[4]  = '{0, 0, 8'h00, 6'b100001};
    vecs[5]  = '{0, 1, 8'h34, 6'b100001};
    vecs[6]  = '{0, 1, 8'h56, 6'b100001};
    vecs[7]  = '{0, 1, 8'h78, 6'b010101};
    vecs[8]  = '{0, 0, 8'h00, 6'b010001};
    vecs[9]  = '{0, 0, 8'h00, 6'b010001};
    vecs[10] = '{0, 0, 8'h00, 6'b011001};
    cap = 0; flen = 0; idle = 0; gap_last = -1; last_len = 0; last_word = 0;

    step(1, 0, 0);
    step(1, 0, 0);
    chk("reset_state", 64'(dut_out()), 64'(6'b100000));

    // Table: reset with valid byte, gapped fill of 0x12345678, first frame bits
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].lv, vecs[i].d);
      chk($sformatf("vec%0d", i), 64'(dut_out()), 64'(vecs[i].exp));
    end
    for (int i = 0; i < 30; i++) step(0, 0, 0);
    chk("gapped_word", last_word[31:0], 32'h12345678);
    chk("gapped_len", last_len, W);

    // Back-to-back DEADBEEF
    load_word(32'hDEADBEEF);
    for (int i = 0; i < 33; i++) step(0, 0, 0);
    chk("deadbeef_word", last_word[31:0], 32'hDEADBEEF);
    chk("deadbeef_len", last_len, W);

    // load_valid held high with 0xFF throughout the frame
    load_word(32'hA5A5A5A5);
    for (int i = 0; i < 34; i++) step(0, 1, 8'hFF);
    chk("hold_valid_word", last_word[31:0], 32'hA5A5A5A5);
    chk("hold_valid_len", last_len, W);
    step(1, 0, 0);

    // Reset in the middle of a frame
    load_word(32'h11223344);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    step(1, 1, 8'h99);
    chk("midrst_outputs", 64'(dut_out()), 64'(6'b100000));
    load_word(32'hCAFEF00D);
    for (int i = 0; i < 33; i++) step(0, 0, 0);
    chk("after_rst_word", last_word[31:0], 32'hCAFEF00D);
    chk("after_rst_len", last_len, W);

    // Two frames at maximum rate
    words.delete();
    pend = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF0, 8'hE0, 8'hD0, 8'hC0};
    for (int i = 0; i < 90; i++) begin
      was_ready = load_ready;
      step(0, pend.size() > 0, pend.size() > 0 ? pend[0] : 8'h00);
      if (was_ready && pend.size() > 0) void'(pend.pop_front());
    end
    chk("maxrate_frames", words.size(), 2);
    if (words.size() == 2) begin
      chk("maxrate_word0", words[0], 32'h01020304);
      chk("maxrate_word1", words[1], 32'hF0E0D0C0);
    end
    chk("maxrate_gap", gap_last, 4);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++)
      step(($urandom_range(99) == 0), ($urandom_range(2) != 0), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
